snake_frame_scheduler: RTL

//   Sequences and arbitrates the single grid memory shared by the VGA reader and the snake writer.

---
 rtl/snake_frame_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/snake_frame_scheduler.sv
// rtl/snake_frame_scheduler.sv - frame-tick generator and grid-memory arbiter for the snake sweep
module snake_frame_scheduler #(
    parameter int GRID_W      = 30,
    parameter int GRID_H      = 30,
    parameter int TICK_FRAMES = 8,
    parameter int SETTLE_CYC  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vblank,
    input  logic       vga_req,
    input  logic [4:0] vga_x,
    input  logic [4:0] vga_y,
    input  logic [1:0] sw_data,
    output logic [4:0] sweep_x,
    output logic [4:0] sweep_y,
    output logic [4:0] mem_x,
    output logic [4:0] mem_y,
    output logic       mem_we,
    output logic [1:0] mem_wdata,
    output logic       game_tick,
    output logic       sweep_busy,
    output logic       overrun
);

    localparam int FCW = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [FCW-1:0] FRAME_LAST  = FCW'(TICK_FRAMES - 1);
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYC - 1);
    localparam logic [4:0]     X_LAST      = 5'(GRID_W - 1);
    localparam logic [4:0]     Y_LAST      = 5'(GRID_H - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TICK   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_SWEEP  = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic [SCW-1:0] settle_cnt_q, settle_cnt_d;
    logic [4:0]     sweep_x_q, sweep_x_d;
    logic [4:0]     sweep_y_q, sweep_y_d;
    logic           tick_pend_q, tick_pend_d;
    logic           overrun_q, overrun_d;
    logic           vblank_q, vblank_d;

    logic vblank_rise;
    logic tick_due;
    logic grant;
    logic last_cell;

    // Frame counting, tick scheduling, sweep sequencing and overrun tracking
    always_comb begin
        vblank_d     = vblank;
        frame_cnt_d  = frame_cnt_q;
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        sweep_x_d    = sweep_x_q;
        sweep_y_d    = sweep_y_q;
        tick_pend_d  = tick_pend_q;
        overrun_d    = overrun_q;

        vblank_rise = vblank && !vblank_q;
        tick_due    = vblank_rise && (frame_cnt_q == FRAME_LAST);
        grant       = (state_q == ST_SWEEP) && !vga_req;
        last_cell   = (sweep_x_q == X_LAST) && (sweep_y_q == Y_LAST);

        if (vblank_rise) begin
            frame_cnt_d = tick_due ? '0 : frame_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick_due || tick_pend_q) begin
                    state_d     = ST_TICK;
                    tick_pend_d = 1'b0;
                end
            end
            ST_TICK: begin
                settle_cnt_d = SETTLE_LOAD;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d   = ST_SWEEP;
                    sweep_x_d = 5'd0;
                    sweep_y_d = 5'd0;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            default: begin
                // Address advances only on cycles the sweep actually owned the port.
                if (grant) begin
                    if (last_cell) begin
                        state_d   = ST_IDLE;
                        sweep_x_d = 5'd0;
                        sweep_y_d = 5'd0;
                    end else if (sweep_x_q == X_LAST) begin
                        sweep_x_d = 5'd0;
                        sweep_y_d = sweep_y_q + 5'd1;
                    end else begin
                        sweep_x_d = sweep_x_q + 5'd1;
                    end
                end
            end
        endcase

        // A tick landing while a sweep is in flight is held (only one) and flagged.
        if (tick_due && (state_q != ST_IDLE)) begin
            tick_pend_d = 1'b1;
            overrun_d   = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= '0;
            settle_cnt_q <= '0;
            sweep_x_q    <= 5'd0;
            sweep_y_q    <= 5'd0;
            tick_pend_q  <= 1'b0;
            overrun_q    <= 1'b0;
            vblank_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            sweep_x_q    <= sweep_x_d;
            sweep_y_q    <= sweep_y_d;
            tick_pend_q  <= tick_pend_d;
            overrun_q    <= overrun_d;
            vblank_q     <= vblank_d;
        end
    end

    // Memory port mux: VGA owns the port unless the sweep is granted this cycle
    always_comb begin
        mem_x     = vga_x;
        mem_y     = vga_y;
        mem_we    = 1'b0;
        mem_wdata = 2'b00;
        if (grant) begin
            mem_x     = sweep_x_q;
            mem_y     = sweep_y_q;
            mem_we    = 1'b1;
            mem_wdata = sw_data;
        end
    end

    assign sweep_x    = sweep_x_q;
    assign sweep_y    = sweep_y_q;
    assign game_tick  = (state_q == ST_TICK);
    assign sweep_busy = (state_q == ST_SETTLE) || (state_q == ST_SWEEP);
    assign overrun    = overrun_q;

endmodule
